sram_pair_sequencer: RTL

//  Command-driven read sequencer for the dual-address SRAM. Takes a base address and a pair count,

---
 rtl/sram_seq_pkg.sv | 16 +
 rtl/sram_valid_delay.sv | 57 +++++
 rtl/sram_pair_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/sram_seq_pkg.sv
// Shared definitions for the SRAM pair read sequencer.
// Contents: state encodings for the control FSM and the default widths and read latency.
// No ports; imported by sram_valid_delay and sram_pair_sequencer.
package sram_seq_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_RD_LAT = 1;

  // Control FSM states, kept as plain constants so older blocks can share the encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sram_valid_delay.sv
// RD_LAT-stage shift register of {valid,last} that lines read qualifiers up with SRAM data.
// Ports: clock/reset (sync, active-high clear), vld_i/last_i (issued read), tag_last_i
// (mark youngest in-flight read as last), vld_o/last_o (aligned with data), any_valid_o.
module sram_valid_delay
  import sram_seq_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic clock,
  input  logic reset,
  input  logic vld_i,
  input  logic last_i,
  input  logic tag_last_i,
  output logic vld_o,
  output logic last_o,
  output logic any_valid_o
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] last_q, last_d;
  logic              found;

  always_comb begin
    vld_d    = vld_q;
    last_d   = last_q;
    found    = 1'b0;
    vld_d[0]  = vld_i;
    last_d[0] = last_i;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      last_d[k] = last_q[k-1];
    end
    // Retro-tag: stage 0 holds the newest entry after the shift, so the first valid
    // stage scanning upward is the most recently issued read still in flight.
    for (int k = 0; k < RD_LAT; k++) begin
      if (tag_last_i && !found && vld_d[k]) begin
        last_d[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign vld_o       = vld_q[RD_LAT-1];
  assign last_o      = last_q[RD_LAT-1] & vld_q[RD_LAT-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/sram_pair_sequencer.sv
// Command-driven read sequencer issuing even/odd address pairs to the dual-address SRAM.
// Ports: clock/reset (sync, active-high); start/base_addr/num_pairs command; abort; out_ready
// backpressure; busy/done status; rd_en/addr1/addr2 to SRAM; data_valid/last aligned to read data.
module sram_pair_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_pairs,
  input  logic              abort,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              data_valid,
  output logic              last
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic              last_q, last_d;
  logic              tag_last;
  logic              any_valid;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rem_d    = rem_q;
    rd_en_d  = 1'b0;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    last_d   = 1'b0;
    tag_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d   = {base_addr[ADDR_W-1:1], 1'b0};
          rem_d   = num_pairs;
          state_d = (num_pairs == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          // Stop issuing; whatever is already in flight completes, newest one carries last.
          state_d  = ST_DRAIN;
          tag_last = 1'b1;
        end else if (out_ready) begin
          rd_en_d = 1'b1;
          addr1_d = cur_q;
          addr2_d = cur_q + ADDR_W'(1);
          cur_d   = cur_q + ADDR_W'(2);
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            last_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // rd_en_q is checked too: the final pair may not have entered the pipe yet.
        if (!rd_en_q && !any_valid) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      rd_en_q <= 1'b0;
      addr1_q <= '0;
      addr2_q <= ADDR_W'(1);
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      rd_en_q <= rd_en_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      last_q  <= last_d;
    end
  end

  sram_valid_delay #(
    .RD_LAT(RD_LAT)
  ) u_valid_delay (
    .clock      (clock),
    .reset      (reset),
    .vld_i      (rd_en_q),
    .last_i     (last_q),
    .tag_last_i (tag_last),
    .vld_o      (data_valid),
    .last_o     (last),
    .any_valid_o(any_valid)
  );

  assign busy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done  = (state_q == ST_DONE);
  assign rd_en = rd_en_q;
  assign addr1 = addr1_q;
  assign addr2 = addr2_q;

endmodule
